// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the round-robin arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int ARB_N     = 4;
    localparam int ARB_IDX_W = 2;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Priority pointer after an owner leaves: the requester just past it.
    function automatic logic [ARB_IDX_W-1:0] arb_next_ptr(input logic [ARB_IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_4
// Description : Combinational circular first-set-bit picker starting at i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     i_req,
    input  logic [ARB_IDX_W-1:0] i_ptr,
    output logic                 o_found,
    output logic [ARB_IDX_W-1:0] o_idx
);

    logic [ARB_IDX_W-1:0] w_cand;

    // Scan from farthest to nearest so the closest set bit to i_ptr wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_ptr;
        w_cand  = i_ptr;
        for (int k = ARB_N - 1; k >= 0; k--) begin
            w_cand = i_ptr + ARB_IDX_W'(k);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule : rr_pick_4
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4
// Description : Four-requester round-robin arbiter with registered grant index
//               and grant-valid outputs. Optional forced release after
//               MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ARB_N-1:0]     req,
    input  logic                 release_,
    output logic                 grant_valid,
    output logic [ARB_IDX_W-1:0] grant_index,
    output logic [CNT_W-1:0]     busy_cycles,
    output logic                 timeout
);

    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 255 || (1 << CNT_W) <= MAX_HOLD) begin : g_param_check
            $error("rr_arbiter_4: MAX_HOLD must be 2..255 and below 2**CNT_W");
        end
    endgenerate

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [ARB_IDX_W-1:0] r_ptr;
    logic [ARB_IDX_W-1:0] w_ptr_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic [ARB_IDX_W-1:0] r_idx;
    logic [ARB_IDX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0]     r_busy;
    logic [CNT_W-1:0]     w_busy_nxt;

    logic                 w_found;
    logic [ARB_IDX_W-1:0] w_pick;
    logic                 w_exit_normal;
    logic                 w_force;
    logic                 w_exit;

    rr_pick_4 u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // A normal exit is a release strobe or the owner dropping its request.
    assign w_exit_normal = (r_state == ARB_GRANT) && (release_ || !req[r_idx]);

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic r_timeout;

    assign w_force = (r_state == ARB_GRANT) && (r_busy == c_HOLD_LAST) && !w_exit_normal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    assign w_exit = w_exit_normal || w_force;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_busy  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_valid <= w_valid_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:  if (w_found) w_state_nxt = ARB_GRANT;
            ARB_GRANT: if (w_exit)  w_state_nxt = ARB_IDLE;
            default:                w_state_nxt = ARB_IDLE;
        endcase
    end

    // Index and counter are left untouched in the bubble cycle after a grant.
    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_valid_nxt = r_valid;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        case (r_state)
            ARB_IDLE: begin
                w_valid_nxt = 1'b0;
                if (w_found) begin
                    w_valid_nxt = 1'b1;
                    w_idx_nxt   = w_pick;
                    w_busy_nxt  = '0;
                end
            end
            ARB_GRANT: begin
                if (w_exit) begin
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = arb_next_ptr(r_idx);
                end else if (!(&r_busy)) begin
                    w_busy_nxt = r_busy + 1'b1;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign grant_valid = r_valid;
    assign grant_index = r_idx;
    assign busy_cycles = r_busy;

endmodule : rr_arbiter_4
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_4
// Description : Directed self-checking bench for rr_arbiter_4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       release_ = 1'b0;
    logic       gv;
    logic [1:0] gi;
    logic [7:0] busy;
    logic       tmo;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .release_    (release_),
        .grant_valid (gv),
        .grant_index (gi),
        .busy_cycles (busy),
        .timeout     (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        step(); step();
        n_cmp++; if (gv !== 1'b0)    begin n_err++; $display("FAIL reset_gv: got %0d expected 0", gv); end
        n_cmp++; if (gi !== 2'd0)    begin n_err++; $display("FAIL reset_gi: got %0d expected 0", gi); end
        n_cmp++; if (busy !== 8'd0)  begin n_err++; $display("FAIL reset_busy: got %0d expected 0", busy); end
        n_cmp++; if (tmo !== 1'b0)   begin n_err++; $display("FAIL reset_tmo: got %0d expected 0", tmo); end
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            n_cmp++; if (gv !== 1'b0) begin n_err++; $display("FAIL idle_gv cycle %0d: got %0d expected 0", k, gv); end
        end
    endtask

    task automatic test_single;
        req = 4'b0100;
        step();
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd2 || busy !== 8'd0)
            begin n_err++; $display("FAIL single_grant: got gv=%0d gi=%0d busy=%0d expected 1/2/0", gv, gi, busy); end
        step();
        n_cmp++; if (busy !== 8'd1) begin n_err++; $display("FAIL single_busy1: got %0d expected 1", busy); end
        step();
        n_cmp++; if (busy !== 8'd2) begin n_err++; $display("FAIL single_busy2: got %0d expected 2", busy); end
        release_ = 1'b1;
        step();
        release_ = 1'b0;
        n_cmp++; if (gv !== 1'b0 || gi !== 2'd2)
            begin n_err++; $display("FAIL single_bubble: got gv=%0d gi=%0d expected 0/2", gv, gi); end
        step();
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd2 || busy !== 8'd0)
            begin n_err++; $display("FAIL single_regrant: got gv=%0d gi=%0d busy=%0d expected 1/2/0", gv, gi, busy); end
        release_ = 1'b1;
        req = 4'b1111;
        step();
        release_ = 1'b0;
        n_cmp++; if (gv !== 1'b0) begin n_err++; $display("FAIL single_bubble2: got %0d expected 0", gv); end
        step();
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd3)
            begin n_err++; $display("FAIL single_ptr3: got gv=%0d gi=%0d expected 1/3", gv, gi); end
        release_ = 1'b1;
        req = 4'b0000;
        step();
        release_ = 1'b0;
        step();
        n_cmp++; if (gv !== 1'b0) begin n_err++; $display("FAIL single_idle: got %0d expected 0", gv); end
    endtask

    task automatic test_rotation;
        logic [1:0] exp_idx;
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            exp_idx = 2'(k % 4);
            n_cmp++; if (gv !== 1'b1 || gi !== exp_idx)
                begin n_err++; $display("FAIL rot_grant %0d: got gv=%0d gi=%0d expected 1/%0d", k, gv, gi, exp_idx); end
            step();
            release_ = 1'b1;
            step();
            release_ = 1'b0;
            n_cmp++; if (gv !== 1'b0) begin n_err++; $display("FAIL rot_bubble %0d: got %0d expected 0", k, gv); end
            step();
        end
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd1)
            begin n_err++; $display("FAIL rot_next: got gv=%0d gi=%0d expected 1/1", gv, gi); end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_abandon_wrap;
        req = 4'b1000;
        step();
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd3)
            begin n_err++; $display("FAIL abandon_grant: got gv=%0d gi=%0d expected 1/3", gv, gi); end
        step();
        req = 4'b0011;
        step();
        n_cmp++; if (gv !== 1'b0 || gi !== 2'd3)
            begin n_err++; $display("FAIL abandon_bubble: got gv=%0d gi=%0d expected 0/3", gv, gi); end
        step();
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd0)
            begin n_err++; $display("FAIL abandon_wrap: got gv=%0d gi=%0d expected 1/0", gv, gi); end
        req = 4'b0111;
        step();
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd0 || busy !== 8'd1)
            begin n_err++; $display("FAIL nonowner_ignored: got gv=%0d gi=%0d busy=%0d expected 1/0/1", gv, gi, busy); end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_async_reset;
        req = 4'b0010;
        step();
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd1)
            begin n_err++; $display("FAIL areset_pre: got gv=%0d gi=%0d expected 1/1", gv, gi); end
        step();
        step();
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (gv !== 1'b0 || busy !== 8'd0 || gi !== 2'd0)
            begin n_err++; $display("FAIL areset_mid: got gv=%0d busy=%0d gi=%0d expected 0/0/0", gv, busy, gi); end
        req = 4'b1000;
        step();
        rst = 1'b1;
        step();
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd3)
            begin n_err++; $display("FAIL areset_after: got gv=%0d gi=%0d expected 1/3", gv, gi); end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_hold;
        req = 4'b0001;
        step();
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd0 || busy !== 8'd0)
            begin n_err++; $display("FAIL hold_grant: got gv=%0d gi=%0d busy=%0d expected 1/0/0", gv, gi, busy); end
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < 4; k++) begin
            step();
            n_cmp++; if (gv !== 1'b1 || busy !== 8'(k) || tmo !== 1'b0)
                begin n_err++; $display("FAIL hold_cycle %0d: got gv=%0d busy=%0d tmo=%0d expected 1/%0d/0", k, gv, busy, tmo, k); end
        end
        step();
        n_cmp++; if (gv !== 1'b0 || tmo !== 1'b1)
            begin n_err++; $display("FAIL timeout_pulse: got gv=%0d tmo=%0d expected 0/1", gv, tmo); end
        step();
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd0 || busy !== 8'd0 || tmo !== 1'b0)
            begin n_err++; $display("FAIL timeout_regrant: got gv=%0d gi=%0d busy=%0d tmo=%0d expected 1/0/0/0", gv, gi, busy, tmo); end
        step(); step(); step();
        release_ = 1'b1;
        step();
        release_ = 1'b0;
        n_cmp++; if (gv !== 1'b0 || tmo !== 1'b0)
            begin n_err++; $display("FAIL timeout_coincide: got gv=%0d tmo=%0d expected 0/0", gv, tmo); end
`else
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 10) begin
                n_cmp++; if (busy !== 8'd10) begin n_err++; $display("FAIL hold_busy10: got %0d expected 10", busy); end
            end
        end
        n_cmp++; if (gv !== 1'b1 || gi !== 2'd0 || busy !== 8'd255 || tmo !== 1'b0)
            begin n_err++; $display("FAIL hold_saturate: got gv=%0d gi=%0d busy=%0d tmo=%0d expected 1/0/255/0", gv, gi, busy, tmo); end
`endif
        req = 4'b0000;
        step();
        n_cmp++; if (gv !== 1'b0) begin n_err++; $display("FAIL hold_drop: got %0d expected 0", gv); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_abandon_wrap();
        test_async_reset();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rr_arbiter_4
`default_nettype wire

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that owns one shared resource, such as a bus port or a shared register-file write port.
- Produces a registered 2-bit grant index plus a grant-valid strobe. These drive the `ena`/`in` inputs of the 2-to-4 decoder directly downstream, which expands them into one-hot grant lines.
- A grant is held until the owner releases it, or drops its request.
- Fairness comes from a rotating priority pointer.

Parameters:
- MAX_HOLD, 16, cycles one owner may hold a grant before forced release (only used with ARB_TIMEOUT_EN); legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  4  request lines; req[i] high = requester i wants the resource.
- release_  input  1  owner's one-cycle release strobe; sampled only while grant_valid=1.
- grant_valid  output  1  a grant is active; feeds decoder ena.
- grant_index  output  2  index of current owner; feeds decoder in.
- busy_cycles  output  CNT_W  cycles the current grant has been held (0 on first grant cycle).
- timeout  output  1  one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset (rst low, async): state=IDLE, pointer=0, grant_valid=0, grant_index=0, busy_cycles=0, timeout=0. Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- Two-state FSM, states IDLE and GRANT. All outputs are registered; there is no combinational path from req to grant outputs.
- IDLE:
  - If req!=0 at a clock edge, select the first set bit scanning circularly from pointer: pointer, pointer+1, … mod 4.
  - Load that bit into grant_index, set grant_valid=1, clear busy_cycles, go to GRANT.
  - Latency: req sampled at edge N gives grant_valid high after edge N.
  - If req==0, stay in IDLE; outputs are unchanged except grant_valid=0.
- GRANT:
  - busy_cycles increments each cycle and saturates at all-ones.
  - Exit condition at an edge: release_=1, OR req[grant_index]=0 (abandon).
  - On exit: pointer=grant_index+1 (2-bit wrap, 3→0), grant_valid=0, go to IDLE.
  - Exactly one bubble cycle of grant_valid=0 follows every grant. grant_index keeps its last value during the bubble.
- Simultaneous release_ and req[grant_index] still high: release wins. The same requester may win again only after the pointer has passed it.
- Changes to req on non-owner bits during GRANT have no effect until IDLE.
- release_ while grant_valid=0 is ignored.
- Starvation bound: with all four requests continuously high, each requester is granted at least once every 4 grants.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when busy_cycles==MAX_HOLD-1 and no other exit condition holds, the next edge forces release: same pointer update, go to IDLE, timeout=1 for that one cycle.
  - If a normal exit coincides with the timeout edge, it is a normal exit and timeout stays 0.
- Not defined: no forced release, the timeout port is driven constant 0, and MAX_HOLD is unused.

Decomposition:
- Shared package arb_pkg holds:
  - the enum arb_state_t {ARB_IDLE, ARB_GRANT};
  - localparam ARB_N=4 and ARB_IDX_W=2.
- One natural sub-module: rr_pick_4. It is combinational; given req[3:0] and pointer[1:0] it returns a found flag and the winning index. It is reusable by other arbiters.
- The downstream one-hot expansion is left to the existing 2-to-4 decoder and is not duplicated here.

Test Plan:
- Reset then idle: rst low → all outputs 0. Release reset with req=0000 for 10 cycles → grant_valid stays 0.
- Single request: req=0100 at edge N → grant_valid=1, grant_index=2 after edge N. release_ pulse at edge N+3 → grant_valid=0 for exactly one cycle, pointer=3.
- Fair rotation: req=1111 held, and each owner releases after 2 cycles → grant_index sequence 0,1,2,3,0 with one bubble between grants.
- Abandon and wrap: owner 3 drops req[3] with req=0011 present → bubble, then grant_index=0 (pointer wrapped 3→0).
- Async reset mid-grant: rst falls between clock edges while grant_valid=1 → grant_valid=0 and busy_cycles=0 before the next edge. After release of reset, req=1000 → grant_index=3.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=0001 held, no release_ → grant held 4 cycles, timeout pulses once, bubble, then grant_index=0 again. Without the macro, the grant holds indefinitely and busy_cycles saturates at 255.
